// File: rtl/pulse_stretcher_pkg.sv
// ============================================================================
// pulse_stretcher_pkg : FSM state encodings and sizing helper. Rev 1.0
// ============================================================================
`default_nettype none

package pulse_stretcher_pkg;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_HIGH = 2'd1;
  localparam state_t ST_GAP  = 2'd2;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

`default_nettype wire

// File: rtl/pulse_stretcher_if.sv
// ============================================================================
// pulse_stretcher_if : event strobe in, stretched pulse and status out. Rev 1.0
// ============================================================================
`default_nettype none

interface pulse_stretcher_if #(
  parameter int MAX_PEND = 3
);

  localparam int PEND_W = $clog2(MAX_PEND + 1);

  logic              pulse_in;
  logic              level_out;
  logic              busy;
  logic [PEND_W-1:0] pending;
  logic              overflow;

  modport master (
    output pulse_in,
    input  level_out,
    input  busy,
    input  pending,
    input  overflow
  );

  modport slave (
    input  pulse_in,
    output level_out,
    output busy,
    output pending,
    output overflow
  );

endinterface

`default_nettype wire

// File: rtl/pulse_stretcher_hold_timer.sv
// ============================================================================
// hold_timer : loadable down-counter flagging the last cycle of a phase. Rev 1.0
// ============================================================================
`default_nettype none

module hold_timer #(
  parameter int WIDTH = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic             done
);

  logic [WIDTH-1:0] count;

  // Holds at zero instead of wrapping; a phase of N cycles loads N.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (count != '0) begin
      count <= count - WIDTH'(1);
    end
  end

  assign done = (count == WIDTH'(1));

endmodule

`default_nettype wire

// File: rtl/pulse_stretcher.sv
// ============================================================================
// pulse_stretcher : stretches event strobes into fixed-width, spaced pulses. Rev 1.0
// ============================================================================
`default_nettype none

module pulse_stretcher
  import pulse_stretcher_pkg::*;
#(
  parameter int HIGH_CYCLES = 4,
  parameter int GAP_CYCLES  = 2,
  parameter int MAX_PEND    = 3
) (
  input  logic                    clk,
  input  logic                    rst_n,
  pulse_stretcher_if.slave        bus
);

  localparam int PEND_W = $clog2(MAX_PEND + 1);
  localparam int TMR_W  = $clog2(max_int(HIGH_CYCLES, GAP_CYCLES) + 1);

  localparam logic [PEND_W-1:0] PEND_MAX  = PEND_W'(MAX_PEND);
  localparam logic [TMR_W-1:0]  HIGH_LOAD = TMR_W'(HIGH_CYCLES);
  localparam logic [TMR_W-1:0]  GAP_LOAD  = TMR_W'(GAP_CYCLES);

  state_t            state, state_nxt;
  logic [PEND_W-1:0] pending, pending_nxt;
  logic              level, busy, overflow, overflow_nxt;
  logic              timer_load, timer_done;
  logic [TMR_W-1:0]  timer_val;
  logic              inc, dec;

  hold_timer #(.WIDTH(TMR_W)) u_hold_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (timer_load),
    .load_val (timer_val),
    .done     (timer_done)
  );

  always_comb begin
    state_nxt    = state;
    timer_load   = 1'b0;
    timer_val    = '0;
    inc          = bus.pulse_in && (state != ST_IDLE);
    // An event arriving on the last gap cycle is consumed by that same transition.
    dec          = (state == ST_GAP) && timer_done && ((pending != '0) || bus.pulse_in);
    case (state)
      ST_IDLE: begin
        if (bus.pulse_in) begin
          state_nxt  = ST_HIGH;
          timer_load = 1'b1;
          timer_val  = HIGH_LOAD;
        end
      end
      ST_HIGH: begin
        if (timer_done) begin
          state_nxt  = ST_GAP;
          timer_load = 1'b1;
          timer_val  = GAP_LOAD;
        end
      end
      ST_GAP: begin
        if (timer_done) begin
          timer_load = 1'b1;
          if (dec) begin
            state_nxt = ST_HIGH;
            timer_val = HIGH_LOAD;
          end else begin
            state_nxt = ST_IDLE;
          end
        end
      end
      default: state_nxt = ST_IDLE;
    endcase

    pending_nxt  = pending;
    overflow_nxt = 1'b0;
    if (inc && !dec) begin
      if (pending == PEND_MAX) begin
        overflow_nxt = 1'b1;
      end else begin
        pending_nxt = pending + PEND_W'(1);
      end
    end else if (dec && !inc) begin
      pending_nxt = pending - PEND_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      pending  <= '0;
      level    <= 1'b0;
      busy     <= 1'b0;
      overflow <= 1'b0;
    end else begin
      state    <= state_nxt;
      pending  <= pending_nxt;
      level    <= (state_nxt == ST_HIGH);
      busy     <= (state_nxt != ST_IDLE);
      overflow <= overflow_nxt;
    end
  end

  assign bus.level_out = level;
  assign bus.busy      = busy;
  assign bus.pending   = pending;
  assign bus.overflow  = overflow;

endmodule

`default_nettype wire

// File: tb/tb_pulse_stretcher.sv
// ============================================================================
// tb_pulse_stretcher : directed and random checks against a schedule model. Rev 1.0
// ============================================================================
`default_nettype none

module tb_pulse_stretcher;

  localparam int H  = 4;
  localparam int G  = 2;
  localparam int MP = 3;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  int checks     = 0;
  int failures   = 0;
  int cyc        = 0;
  int last_drop  = -10;
  int rises      = 0;
  int highs      = 0;
  int ovf_count  = 0;
  logic prev_level = 1'b0;

  // Model: accepted event cycles and the cycle each one's pulse starts.
  int acc_t[$];
  int st[$];

  pulse_stretcher_if #(.MAX_PEND(MP)) bus ();

  pulse_stretcher #(
    .HIGH_CYCLES (H),
    .GAP_CYCLES  (G),
    .MAX_PEND    (MP)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  function automatic int model_pending(input int c);
    int n = 0;
    foreach (acc_t[i]) if (acc_t[i] < c && st[i] > c) n++;
    return n;
  endfunction

  function automatic bit model_level(input int c);
    foreach (st[i]) if (st[i] <= c && c < st[i] + H) return 1'b1;
    return 1'b0;
  endfunction

  function automatic bit model_busy(input int c);
    foreach (st[i]) if (st[i] <= c && c < st[i] + H + G) return 1'b1;
    return 1'b0;
  endfunction

  function automatic bit model_has_start(input int c);
    foreach (st[i]) if (st[i] == c) return 1'b1;
    return 1'b0;
  endfunction

  function automatic bit would_drop(input int c);
    return (model_pending(c) == MP) && !model_has_start(c + 1);
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, got, exp);
    end
  endtask

  // Called at a falling edge: check this cycle's outputs, then drive this cycle's input.
  task automatic step(input bit p);
    int s;
    check("level_out", 32'(bus.level_out), 32'(model_level(cyc)));
    check("busy",      32'(bus.busy),      32'(model_busy(cyc)));
    check("pending",   32'(bus.pending),   32'(model_pending(cyc)));
    check("overflow",  32'(bus.overflow),  32'(last_drop == cyc - 1));
    if (bus.level_out === 1'b1 && prev_level == 1'b0) rises++;
    if (bus.level_out === 1'b1) highs++;
    if (bus.overflow === 1'b1) ovf_count++;
    prev_level = bus.level_out;
    bus.pulse_in = p;
    if (p) begin
      if (would_drop(cyc)) begin
        last_drop = cyc;
      end else begin
        s = (st.size() == 0) ? cyc + 1 : ((cyc + 1 > st[$] + H + G) ? cyc + 1 : st[$] + H + G);
        acc_t.push_back(cyc);
        st.push_back(s);
      end
    end
    cyc++;
    @(negedge clk);
  endtask

  task automatic drain();
    repeat (40) step(1'b0);
  endtask

  task automatic do_reset();
    bus.pulse_in = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("rst_level",    32'(bus.level_out), 32'd0);
    check("rst_busy",     32'(bus.busy),      32'd0);
    check("rst_pending",  32'(bus.pending),   32'd0);
    check("rst_overflow", 32'(bus.overflow),  32'd0);
    rst_n = 1'b1;
    acc_t.delete();
    st.delete();
    cyc = 0; last_drop = -10; rises = 0; highs = 0; ovf_count = 0; prev_level = 1'b0;
  endtask

  initial begin
    bus.pulse_in = 1'b0;
    do_reset();

    // Single event
    step(1'b1);
    drain();
    check("single_pulses", 32'(rises), 32'd1);
    check("single_width",  32'(highs), 32'(H));

    // Back-to-back events queue and emit in order
    do_reset();
    repeat (3) step(1'b1);
    drain();
    check("three_pulses", 32'(rises), 32'd3);

    // Fifth event overflows the queue
    do_reset();
    repeat (5) step(1'b1);
    drain();
    check("ovf_pulses", 32'(rises), 32'd4);
    check("ovf_strobes", 32'(ovf_count), 32'd1);

    // Full queue plus event on last gap cycle: no overflow
    do_reset();
    repeat (4) step(1'b1);
    step(1'b0);
    step(1'b0);
    step(1'b1);
    drain();
    check("gapend_pulses", 32'(rises), 32'd5);
    check("gapend_ovf", 32'(ovf_count), 32'd0);

    // Asynchronous reset in the middle of a pulse with two queued
    do_reset();
    repeat (3) step(1'b1);
    check("pre_rst_level",   32'(bus.level_out), 32'd1);
    check("pre_rst_pending", 32'(bus.pending),   32'd2);
    #2 rst_n = 1'b0;
    #1;
    check("arst_level",   32'(bus.level_out), 32'd0);
    check("arst_busy",    32'(bus.busy),      32'd0);
    check("arst_pending", 32'(bus.pending),   32'd0);
    check("arst_ovf",     32'(bus.overflow),  32'd0);
    @(negedge clk);
    do_reset();
    step(1'b1);
    drain();
    check("post_rst_pulses", 32'(rises), 32'd1);
    check("post_rst_width",  32'(highs), 32'(H));

    // Sparse random stream that never overflows
    do_reset();
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 3) == 0 && !would_drop(cyc)) step(1'b1);
      else step(1'b0);
    end
    drain();
    check("rand_pulses", 32'(rises), 32'(st.size()));
    check("rand_width",  32'(highs), 32'(H * st.size()));
    check("rand_ovf",    32'(ovf_count), 32'd0);

    // Dense random stream with overflows
    do_reset();
    for (int i = 0; i < 300; i++) step(1'($urandom_range(0, 1)));
    drain();
    check("dense_pulses", 32'(rises), 32'(st.size()));
    check("dense_width",  32'(highs), 32'(H * st.size()));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
